// File: rtl/apb_fifo_multi_if.sv
// APB3 bus bundle for the multi-channel FIFO slave; PCLK/PRESET stay outside.
// Handshake: a transfer completes on the rising edge where PSEL&PENABLE is high; PREADY mirrors
// that (zero wait states), and PRDATA/PSLVERR are valid only while PSEL&PENABLE is high.
interface apb_fifo_multi_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_fifo_multi.sv
// APB3 slave with NCH independent FIFO channels, each with DATA/STATUS/CTRL/THRESH registers,
// sticky overflow/underflow flags and a per-channel interrupt.
module apb_fifo_multi #(
  parameter int NCH    = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_fifo_multi_if.slave bus,
  output logic [NCH-1:0]  irq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_e;

  // Storage has no reset; only the bookkeeping around it does.
  logic [DATA_W-1:0] r_mem    [NCH][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [NCH];
  logic [PTR_W-1:0]  r_rd_ptr [NCH];
  logic [CNT_W-1:0]  r_count  [NCH];
  logic [15:0]       r_thresh [NCH];
  logic [NCH-1:0]    r_ovf;
  logic [NCH-1:0]    r_udf;

  logic              w_access;
  logic [3:0]        w_ch;
  reg_e              w_reg;
  logic              w_ch_ok;
  logic              w_aligned;
  logic [CNT_W-1:0]  w_sel_count;
  logic [DATA_W-1:0] w_sel_head;
  logic [15:0]       w_sel_thresh;
  logic              w_sel_ovf;
  logic              w_sel_udf;
  logic              w_sel_empty;
  logic              w_sel_full;
  logic [31:0]       w_status;
  logic              w_err;
  logic [31:0]       w_rdata;
  logic              w_push;
  logic              w_pop;
  logic              w_set_ovf;
  logic              w_set_udf;
  logic              w_flush;
  logic              w_clr;
  logic              w_thr_wr;
  logic              w_unused;

  assign w_access  = bus.PSEL & bus.PENABLE;
  assign w_ch      = bus.PADDR[7:4];
  assign w_reg     = reg_e'(bus.PADDR[3:2]);
  assign w_ch_ok   = 5'(w_ch) < 5'(NCH);
  assign w_aligned = (bus.PADDR[1:0] == 2'b00);
  assign w_unused  = ^{bus.PADDR[31:8], bus.PWDATA};

  always_comb begin
    w_sel_count  = '0;
    w_sel_head   = '0;
    w_sel_thresh = '0;
    w_sel_ovf    = 1'b0;
    w_sel_udf    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (w_ch == 4'(c)) begin
        w_sel_count  = r_count[c];
        w_sel_head   = r_mem[c][r_rd_ptr[c]];
        w_sel_thresh = r_thresh[c];
        w_sel_ovf    = r_ovf[c];
        w_sel_udf    = r_udf[c];
      end
    end
  end

  assign w_sel_empty = (w_sel_count == '0);
  assign w_sel_full  = (w_sel_count == CNT_W'(DEPTH));

  always_comb begin
    w_status                = '0;
    w_status[CNT_W-1:0]     = w_sel_count;
    w_status[16]            = w_sel_empty;
    w_status[17]            = w_sel_full;
    w_status[18]            = w_sel_ovf;
    w_status[19]            = w_sel_udf;
  end

  // Decode of what the addressed access would do; only acted on when w_access is high.
  always_comb begin
    w_err     = 1'b0;
    w_rdata   = '0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
    w_flush   = 1'b0;
    w_clr     = 1'b0;
    w_thr_wr  = 1'b0;
    if (!w_ch_ok || !w_aligned) begin
      w_err = 1'b1;
    end else begin
      case (w_reg)
        REG_DATA: begin
          if (bus.PWRITE) begin
            if (w_sel_full) begin
              w_err     = 1'b1;
              w_set_ovf = 1'b1;
            end else begin
              w_push = 1'b1;
            end
          end else begin
            if (w_sel_empty) begin
              w_err     = 1'b1;
              w_set_udf = 1'b1;
            end else begin
              w_pop   = 1'b1;
              w_rdata = 32'(w_sel_head);
            end
          end
        end
        REG_STATUS: begin
          if (bus.PWRITE) w_err   = 1'b1;
          else            w_rdata = w_status;
        end
        REG_CTRL: begin
          if (bus.PWRITE) begin
            w_flush = bus.PWDATA[0];
            w_clr   = bus.PWDATA[1];
          end
        end
        default: begin
          if (bus.PWRITE) begin
            if (17'(bus.PWDATA[15:0]) > 17'(DEPTH)) w_err    = 1'b1;
            else                                    w_thr_wr = 1'b1;
          end else begin
            w_rdata = {16'd0, w_sel_thresh};
          end
        end
      endcase
    end
  end

  assign bus.PREADY  = w_access;
  assign bus.PSLVERR = w_access & w_err;
  assign bus.PRDATA  = (w_access && !w_err) ? w_rdata : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int c = 0; c < NCH; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_count[c]  <= '0;
        r_thresh[c] <= 16'(DEPTH);
      end
      r_ovf <= '0;
      r_udf <= '0;
    end else if (w_access) begin
      for (int c = 0; c < NCH; c++) begin
        if (w_ch == 4'(c)) begin
          if (w_push) begin
            r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
            r_count[c]  <= r_count[c] + CNT_W'(1);
          end
          if (w_pop) begin
            r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
            r_count[c]  <= r_count[c] - CNT_W'(1);
          end
          if (w_flush) begin
            r_wr_ptr[c] <= '0;
            r_rd_ptr[c] <= '0;
            r_count[c]  <= '0;
          end
          if (w_clr) begin
            r_ovf[c] <= 1'b0;
            r_udf[c] <= 1'b0;
          end
          if (w_set_ovf) r_ovf[c] <= 1'b1;
          if (w_set_udf) r_udf[c] <= 1'b1;
          if (w_thr_wr)  r_thresh[c] <= bus.PWDATA[15:0];
        end
      end
    end
  end

  // A push coinciding with reset is discarded, so the write port is gated too.
  always_ff @(posedge PCLK) begin
    for (int c = 0; c < NCH; c++) begin
      if (!PRESET && w_access && w_push && (w_ch == 4'(c))) begin
        r_mem[c][r_wr_ptr[c]] <= bus.PWDATA[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    irq = '0;
    for (int c = 0; c < NCH; c++) begin
      irq[c] = r_ovf[c] | r_udf[c] |
               ((r_thresh[c] != 16'd0) && (17'(r_count[c]) >= 17'(r_thresh[c])));
    end
  end

endmodule

// File: tb/tb_apb_fifo_multi.sv
// Self-checking bench for apb_fifo_multi: directed scenarios with literal expectations plus
// randomized APB traffic checked every cycle against a queue-based model of the register map.
module tb_apb_fifo_multi;
  localparam int NCH    = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] irq;

  apb_fifo_multi_if bus();

  apb_fifo_multi #(.NCH(NCH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus),
    .irq    (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  // ---------------- behavioural model ----------------
  logic [31:0] exp_q [NCH][$];
  bit          m_ovf [NCH];
  bit          m_udf [NCH];
  int          m_thr [NCH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      m_ovf[c] = 1'b0;
      m_udf[c] = 1'b0;
      m_thr[c] = DEPTH;
    end
  endfunction

  function automatic void model_resp(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
    int ch = int'(addr[7:4]);
    int rg = int'(addr[3:2]);
    int sz;
    rd = '0;
    er = 1'b0;
    if (ch >= NCH || addr[1:0] != 2'b00) begin
      er = 1'b1;
    end else begin
      sz = exp_q[ch].size();
      case (rg)
        0: if (wr) er = (sz == DEPTH);
           else if (sz == 0) er = 1'b1;
           else rd = exp_q[ch][0];
        1: if (wr) er = 1'b1;
           else rd = 32'(sz) | ((sz == 0) ? 32'h1_0000 : 0) | ((sz == DEPTH) ? 32'h2_0000 : 0)
                     | (m_ovf[ch] ? 32'h4_0000 : 0) | (m_udf[ch] ? 32'h8_0000 : 0);
        2: rd = '0;
        default: if (wr) er = (int'(wd[15:0]) > DEPTH);
                 else rd = 32'(m_thr[ch]);
      endcase
    end
    if (er) rd = '0;
  endfunction

  function automatic void model_apply(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    int ch = int'(addr[7:4]);
    int rg = int'(addr[3:2]);
    if (ch >= NCH || addr[1:0] != 2'b00) return;
    case (rg)
      0: if (wr) begin
           if (exp_q[ch].size() == DEPTH) m_ovf[ch] = 1'b1;
           else exp_q[ch].push_back(wd);
         end else begin
           if (exp_q[ch].size() == 0) m_udf[ch] = 1'b1;
           else void'(exp_q[ch].pop_front());
         end
      2: if (wr) begin
           if (wd[0]) exp_q[ch].delete();
           if (wd[1]) begin m_ovf[ch] = 1'b0; m_udf[ch] = 1'b0; end
         end
      3: if (wr && int'(wd[15:0]) <= DEPTH) m_thr[ch] = int'(wd[15:0]);
      default: ;
    endcase
  endfunction

  function automatic logic [NCH-1:0] model_irq();
    logic [NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++)
      v[c] = m_ovf[c] | m_udf[c] | (m_thr[c] != 0 && exp_q[c].size() >= m_thr[c]);
    return v;
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else if (bus.PSEL && bus.PENABLE) model_apply(bus.PADDR, bus.PWRITE, bus.PWDATA);
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [31:0] e_rd;
    logic        e_er;
    logic        acc;
    if (checking) begin
      acc = bus.PSEL & bus.PENABLE;
      e_rd = '0;
      e_er = 1'b0;
      if (acc) model_resp(bus.PADDR, bus.PWRITE, bus.PWDATA, e_rd, e_er);
      check("pready", 32'(bus.PREADY), 32'(acc));
      check("prdata", bus.PRDATA, e_rd);
      check("pslverr", 32'(bus.PSLVERR), 32'(e_er));
      check("irq", 32'(irq), 32'(model_irq()));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] addr_of(input int ch, input int rg);
    return {24'd0, 4'(ch), 2'(rg), 2'b00};
  endfunction

  // Called #1 after a rising edge; returns #1 after the completing edge.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd, input bit rst_mid,
                      output logic [31:0] rd, output logic er);
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wd;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    if (rst_mid) rst = 1'b1;
    @(negedge clk);
    rd = bus.PRDATA;
    er = bus.PSLVERR;
    @(posedge clk); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic wr_reg(input int ch, input int rg, input logic [31:0] wd, output logic er);
    logic [31:0] rd;
    xfer(addr_of(ch, rg), 1'b1, wd, 1'b0, rd, er);
  endtask

  task automatic rd_reg(input int ch, input int rg, output logic [31:0] rd, output logic er);
    xfer(addr_of(ch, rg), 1'b0, 32'd0, 1'b0, rd, er);
  endtask

  task automatic rnd_op();
    int r  = $urandom_range(0, 99);
    int ch = $urandom_range(0, NCH - 1);
    int k;
    logic [31:0] rd;
    logic er;
    if (r < 35)      xfer(addr_of(ch, 0), 1'b1, $urandom(), 1'b0, rd, er);
    else if (r < 65) xfer(addr_of(ch, 0), 1'b0, 32'd0, 1'b0, rd, er);
    else if (r < 75) rd_reg(ch, 1, rd, er);
    else if (r < 80) wr_reg(ch, 2, 32'($urandom_range(0, 3)), er);
    else if (r < 88) wr_reg(ch, 3, 32'($urandom_range(0, DEPTH + 2)), er);
    else if (r < 92) rd_reg(ch, 3, rd, er);
    else if (r < 96) begin
      k = $urandom_range(0, 2);
      if (k == 0)
        xfer(addr_of($urandom_range(NCH, 15), $urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom(), 1'b0, rd, er);
      else if (k == 1)
        xfer(addr_of(ch, $urandom_range(0, 3)) | 32'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
             $urandom(), 1'b0, rd, er);
      else
        rd_reg(ch, 2, rd, er);
    end else if (r < 98) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end else if (r < 99) begin
      bus.PADDR   = addr_of(ch, 0);
      bus.PWRITE  = 1'b1;
      bus.PWDATA  = $urandom();
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      @(posedge clk); #1;
      bus.PSEL    = 1'b0;
    end else begin
      xfer(addr_of(ch, 0), 1'b1, $urandom(), ($urandom_range(0, 3) == 0), rd, er);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;

    check("rst_irq", 32'(irq), 32'd0);
    for (int c = 0; c < NCH; c++) begin
      rd_reg(c, 1, rd, er);
      check("rst_status", rd, 32'h0001_0000);
    end
    rd_reg(0, 3, rd, er);
    check("rst_thresh", rd, 32'd16);

    // in-order push/pop on ch0
    for (int i = 0; i < 16; i++) begin
      wr_reg(0, 0, 32'(i * 10), er);
      check("t1_push_err", 32'(er), 32'd0);
    end
    rd_reg(0, 1, rd, er);
    check("t1_status_full", rd, 32'h0002_0010);
    for (int i = 0; i < 16; i++) begin
      rd_reg(0, 0, rd, er);
      check("t1_pop", rd, 32'(i * 10));
      check("t1_pop_err", 32'(er), 32'd0);
    end
    rd_reg(0, 1, rd, er);
    check("t1_status_empty", rd, 32'h0001_0000);

    // fill ch1, overflow must not overwrite
    for (int i = 0; i < 16; i++) wr_reg(1, 0, 32'h100 + 32'(i), er);
    check("t2_irq", 32'(irq[1]), 32'd1);
    rd_reg(1, 1, rd, er);
    check("t2_status_full", rd, 32'h0002_0010);
    wr_reg(1, 0, 32'hDEAD, er);
    check("t2_ovf_err", 32'(er), 32'd1);
    rd_reg(1, 1, rd, er);
    check("t2_status_ovf", rd, 32'h0006_0010);
    for (int i = 0; i < 16; i++) begin
      rd_reg(1, 0, rd, er);
      check("t2_pop", rd, 32'h100 + 32'(i));
    end
    wr_reg(1, 2, 32'd2, er);

    // underflow on ch2, then clear
    rd_reg(2, 0, rd, er);
    check("t3_udf_err", 32'(er), 32'd1);
    check("t3_udf_rdata", rd, 32'd0);
    rd_reg(2, 1, rd, er);
    check("t3_status_udf", rd, 32'h0009_0000);
    check("t3_irq_set", 32'(irq[2]), 32'd1);
    wr_reg(2, 2, 32'd2, er);
    rd_reg(2, 1, rd, er);
    check("t3_status_clr", rd, 32'h0001_0000);
    check("t3_irq_clr", 32'(irq[2]), 32'd0);

    // channel isolation and pointer wrap
    wr_reg(0, 0, 32'hA, er);
    wr_reg(3, 0, 32'hB, er);
    rd_reg(3, 0, rd, er);
    check("t4_ch3", rd, 32'hB);
    rd_reg(0, 0, rd, er);
    check("t4_ch0", rd, 32'hA);
    for (int i = 0; i < 24; i++) begin
      wr_reg(0, 0, 32'h1000 + 32'(2 * i), er);
      wr_reg(0, 0, 32'h1001 + 32'(2 * i), er);
      rd_reg(0, 0, rd, er);
      check("t4_wrap_a", rd, 32'h1000 + 32'(2 * i));
      rd_reg(0, 0, rd, er);
      check("t4_wrap_b", rd, 32'h1001 + 32'(2 * i));
    end

    // illegal accesses
    rd_reg(NCH, 1, rd, er);
    check("t5_bad_ch", 32'(er), 32'd1);
    xfer(32'h2, 1'b0, 32'd0, 1'b0, rd, er);
    check("t5_misalign_err", 32'(er), 32'd1);
    check("t5_misalign_rd", rd, 32'd0);
    wr_reg(0, 1, 32'hFFFF_FFFF, er);
    check("t5_wr_status", 32'(er), 32'd1);
    wr_reg(0, 3, 32'(DEPTH + 1), er);
    check("t5_thr_big", 32'(er), 32'd1);
    rd_reg(0, 3, rd, er);
    check("t5_thr_kept", rd, 32'd16);
    rd_reg(0, 1, rd, er);
    check("t5_status_kept", rd, 32'h0001_0000);
    wr_reg(0, 3, 32'(DEPTH), er);
    check("t5_thr_max_ok", 32'(er), 32'd0);

    // threshold irq, flush, reset mid-burst
    wr_reg(0, 3, 32'd4, er);
    for (int i = 0; i < 3; i++) wr_reg(0, 0, 32'h50 + 32'(i), er);
    check("t6_irq_below", 32'(irq[0]), 32'd0);
    wr_reg(0, 0, 32'h53, er);
    check("t6_irq_at", 32'(irq[0]), 32'd1);
    wr_reg(0, 2, 32'd1, er);
    rd_reg(0, 1, rd, er);
    check("t6_flush", rd, 32'h0001_0000);
    check("t6_irq_flush", 32'(irq[0]), 32'd0);
    wr_reg(1, 0, 32'h77, er);
    wr_reg(1, 0, 32'h78, er);
    xfer(addr_of(1, 0), 1'b1, 32'h79, 1'b1, rd, er);
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_prdata", bus.PRDATA, 32'd0);
    check("t6_rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    rd_reg(1, 1, rd, er);
    check("t6_rst_status", rd, 32'h0001_0000);
    rd_reg(0, 3, rd, er);
    check("t6_rst_thresh", rd, 32'd16);

    repeat (1500) rnd_op();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
